// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU family (single-cycle and pipelined).
//   - op_t        : 3-bit opcode type, taken from instr[7:5]
//   - OP_ADD..OP_PASS : opcode encodings 3'h0..3'h7
//   - FLAG_C/Z/V  : bit positions of carry, zero and overflow in a packed
//                   flag vector (flags_t)
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD  = 3'h0;
    localparam op_t OP_NOT  = 3'h1;
    localparam op_t OP_SHL  = 3'h2;
    localparam op_t OP_SHR  = 3'h3;
    localparam op_t OP_EQ   = 3'h4;
    localparam op_t OP_GT   = 3'h5;
    localparam op_t OP_SUB  = 3'h6;
    localparam op_t OP_PASS = 3'h7;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;

    typedef logic [2:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU datapath, shared by the single-cycle and the
//   pipelined ALU.
//   Parameter W : operand/result width (power of 2, >= 4)
//   Ports:
//     op     in  3  opcode (OP_ADD..OP_PASS)
//     a, b   in  W  operands; shift amount is b[$clog2(W)-1:0]
//     result out W  operation result
//     c      out 1  carry-out (ADD), borrow (SUB), last bit shifted out
//                   (SHL/SHR, 0 when the shift amount is 0), else 0
//     z      out 1  result == 0
//     v      out 1  signed overflow for ADD/SUB, else 0
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         c,
    output logic         z,
    output logic         v
);

    localparam int SH_W = $clog2(W);

    logic [SH_W-1:0] sh;
    logic [W-1:0]    sum;
    logic [W-1:0]    diff;
    logic            carry;
    logic            borrow;
    logic [W-1:0]    shl_res;
    logic            shl_out;
    logic [W-1:0]    shr_res;
    logic            shr_out;

    assign sh = b[SH_W-1:0];

    // Extending by one bit gives carry/borrow directly in the top bit.
    assign {carry, sum}   = {1'b0, a} + {1'b0, b};
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

    // The extra guard bit catches the last bit shifted out: for SHL it ends
    // up at position W (= a[W-sh]), for SHR at position 0 (= a[sh-1]).
    // A zero shift leaves the guard bit at 0 automatically.
    assign {shl_out, shl_res} = {1'b0, a} << sh;
    assign {shr_res, shr_out} = {a, 1'b0} >> sh;

    always_comb begin
        result = a;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                c      = carry;
                v      = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_NOT:  result = ~a;
            OP_SHL: begin
                result = shl_res;
                c      = shl_out;
            end
            OP_SHR: begin
                result = shr_res;
                c      = shr_out;
            end
            OP_EQ:   result = {{(W-1){1'b0}}, (a == b)};
            OP_GT:   result = {{(W-1){1'b0}}, (a > b)};
            OP_SUB: begin
                result = diff;
                c      = borrow;
                v      = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            default: result = a;
        endcase
    end

    assign z = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Accepts one operation per cycle; result appears 2 cycles after the input
//   transfer when the sink keeps out_ready high.
//   Parameters: W (operand width), CNT_W (completed-operation counter width)
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   input handshake; instr[7:5] opcode, A, B operands
//     out_valid/out_ready output handshake; result, flag_c/z/v
//     ops_done            number of output transfers, wraps modulo 2^CNT_W
//
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high. A producer holding valid keeps its payload stable until the
//   transfer; ready never depends combinationally on the same side's valid.
// ----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       instr,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic [CNT_W-1:0] ops_done
);

    // Stage 1: captured operation
    logic         s1_valid;
    op_t          s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;

    // Stage 2: computed result
    logic         s2_valid;
    logic [W-1:0] s2_result;
    flags_t       s2_flags;

    logic         s1_adv;
    logic         s2_adv;

    logic [W-1:0] core_result;
    logic         core_c;
    logic         core_z;
    logic         core_v;

    // Operand bits below the opcode carry no meaning for this block.
    logic         unused_instr_bits;
    assign unused_instr_bits = ^instr[4:0];

    // A stage may take new data when it is empty or its content leaves.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    alu_core #(.W(W)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_result),
        .c      (core_c),
        .z      (core_z),
        .v      (core_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            // Data registers only load with a real operation, so idle
            // cycles never pull unknown inputs into the pipe.
            if (in_valid) begin
                s1_op <= instr[7:5];
                s1_a  <= A;
                s1_b  <= B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result        <= core_result;
                s2_flags[FLAG_C] <= core_c;
                s2_flags[FLAG_Z] <= core_z;
                s2_flags[FLAG_V] <= core_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done <= '0;
        end else if (s2_valid && out_ready) begin
            ops_done <= ops_done + 1'b1;
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign flag_c    = s2_flags[FLAG_C];
    assign flag_z    = s2_flags[FLAG_Z];
    assign flag_v    = s2_flags[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
//   Directed vector table and hand-written sequences against a W=4 instance,
//   plus a randomized stream against a W=8 instance with a reference model.
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
// ----------------------------------------------------------------------------
module tb_alu_pipe;
    import alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- W=4 instance ----------------
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  instr4;
    logic [3:0]  a4, b4, res4;
    logic        c4, z4, v4;
    logic [15:0] done4;

    alu_pipe #(.W(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .instr(instr4),
        .A(a4), .B(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .result(res4), .flag_c(c4), .flag_z(z4), .flag_v(v4),
        .ops_done(done4)
    );

    // ---------------- W=8 instance ----------------
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  instr8;
    logic [7:0]  a8, b8, res8;
    logic        c8, z8, v8;
    logic [15:0] done8;

    alu_pipe #(.W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .instr(instr8),
        .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(res8), .flag_c(c8), .flag_z(z8), .flag_v(v8),
        .ops_done(done8)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [6:0]  exp4_q[$];   // {result, c, z, v}
    logic [10:0] exp8_q[$];
    logic        mon4_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference for W=8, computed on plain integers.
    function automatic logic [10:0] model8(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        int ai, bi, sa, sb, r, sh;
        logic c, v;
        logic [7:0] res;
        ai = int'(a);
        bi = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[2:0]);
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            OP_ADD: begin
                r = ai + bi;
                c = (r > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            OP_NOT:  r = 255 - ai;
            OP_SHL: begin
                r = ai * (1 << sh);
                c = (sh != 0) && (((ai >> (8 - sh)) & 1) == 1);
            end
            OP_SHR: begin
                r = ai >> sh;
                c = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1);
            end
            OP_EQ:   r = (ai == bi) ? 1 : 0;
            OP_GT:   r = (ai > bi) ? 1 : 0;
            OP_SUB: begin
                r = ai - bi;
                c = (ai < bi);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            default: r = ai;
        endcase
        res = 8'(r & 255);
        return {res, c, (res == 8'd0), v};
    endfunction

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (rst_n && mon4_en && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                check("mon4_unexpected", 32'(res4), 32'hFFFF_FFFF);
            end else begin
                check("mon4_out", 32'({res4, c4, z4, v4}), 32'(exp4_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                check("mon8_unexpected", 32'(res8), 32'hFFFF_FFFF);
            end else begin
                check("mon8_out", 32'({res8, c8, z8, v8}), 32'(exp8_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       v;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    function automatic logic [6:0] pack_vec(input vec_t t);
        return {t.res, t.c, t.z, t.v};
    endfunction

    task automatic drive4(input vec_t t);
        in_valid4 = 1'b1;
        instr4    = {t.op, 5'h15};
        a4        = t.a;
        b4        = t.b;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int guard;

        //            op       A      B      res    c     z     v
        vecs[0]  = '{OP_ADD,  4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{OP_ADD,  4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{OP_SUB,  4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_EQ,   4'h9, 4'h9, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_GT,   4'h2, 4'h9, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{OP_SHL,  4'h9, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{OP_SHR,  4'h9, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_SHR,  4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_NOT,  4'h5, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_PASS, 4'h0, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{OP_SUB,  4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{OP_ADD,  4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{OP_SHL,  4'h3, 4'h6, 4'hC, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_GT,   4'h9, 4'h2, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_EQ,   4'h9, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{OP_SHR,  4'hC, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0};

        rst_n      = 1'b0;
        in_valid4  = 1'b0;
        instr4     = 8'h00;
        a4         = 4'h0;
        b4         = 4'h0;
        out_ready4 = 1'b1;
        in_valid8  = 1'b0;
        instr8     = 8'h00;
        a8         = 8'h00;
        b8         = 8'h00;
        out_ready8 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_in_ready", 32'(in_ready4), 32'd1);
        check("rst_result", 32'(res4), 32'd0);
        check("rst_flags", 32'({c4, z4, v4}), 32'd0);
        check("rst_ops_done", 32'(done4), 32'd0);
        rst_n = 1'b1;

        // Directed vectors, one at a time, latency checked
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive4(vecs[i]);
            @(negedge clk);
            check("vec_in_ready", 32'(in_ready4), 32'd1);
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            @(negedge clk);
            check("vec_early_valid", 32'(out_valid4), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("vec_out_valid", 32'(out_valid4), 32'd1);
            check($sformatf("vec%0d_out", i), 32'({res4, c4, z4, v4}), 32'(pack_vec(vecs[i])));
        end
        @(posedge clk);
        @(negedge clk);
        check("vec_ops_done", 32'(done4), 32'(NV));
        check("vec_drained", 32'(out_valid4), 32'd0);

        // Backpressure: 4 back-to-back ops, sink stalled for 3 cycles
        exp4_q.delete();
        mon4_en = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        drive4(vecs[0]);
        @(negedge clk);
        check("bp_acc0", 32'(in_ready4), 32'd1);
        if (in_ready4) exp4_q.push_back(pack_vec(vecs[0]));
        @(posedge clk); #1;
        drive4(vecs[1]);
        @(negedge clk);
        check("bp_acc1", 32'(in_ready4), 32'd1);
        if (in_ready4) exp4_q.push_back(pack_vec(vecs[1]));
        @(posedge clk); #1;
        drive4(vecs[2]);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready4), 32'd0);
            check("bp_hold_valid", 32'(out_valid4), 32'd1);
            check("bp_hold_data", 32'({res4, c4, z4, v4}), 32'(pack_vec(vecs[0])));
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        @(negedge clk);
        check("bp_acc2", 32'(in_ready4), 32'd1);
        if (in_ready4) exp4_q.push_back(pack_vec(vecs[2]));
        @(posedge clk); #1;
        drive4(vecs[3]);
        @(negedge clk);
        check("bp_acc3", 32'(in_ready4), 32'd1);
        if (in_ready4) exp4_q.push_back(pack_vec(vecs[3]));
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        guard = 0;
        while (exp4_q.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_drain_left", 32'(exp4_q.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_ops_done", 32'(done4), 32'(NV + 4));
        mon4_en = 1'b0;

        // Reset with two ops in flight
        @(posedge clk); #1;
        drive4(vecs[4]);
        @(posedge clk); #1;
        drive4(vecs[5]);
        @(posedge clk); #1;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        check("rstmid_pre_valid", 32'(out_valid4), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(out_valid4), 32'd0);
        check("rstmid_ops_done", 32'(done4), 32'd0);
        check("rstmid_result", 32'(res4), 32'd0);
        check("rstmid_in_ready", 32'(in_ready4), 32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        out_ready4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstmid_no_stale", 32'(out_valid4), 32'd0);
        end
        check("rstmid_ops_done_after", 32'(done4), 32'd0);

        // W=8 randomized stream with random handshakes
        begin : rand8
            int  sent;
            bit  pending;
            sent    = 0;
            pending = 1'b0;
            guard   = 0;
            exp8_q.delete();
            while (sent < 1000 && guard < 20000) begin
                @(posedge clk); #1;
                guard++;
                if (!pending && $urandom_range(0, 3) != 0) begin
                    pending = 1'b1;
                    instr8  = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
                    a8      = 8'($urandom_range(0, 255));
                    b8      = 8'($urandom_range(0, 255));
                end
                in_valid8  = pending;
                out_ready8 = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (pending && in_ready8) begin
                    exp8_q.push_back(model8(instr8[7:5], a8, b8));
                    sent++;
                    pending = 1'b0;
                end
            end
            @(posedge clk); #1;
            in_valid8  = 1'b0;
            out_ready8 = 1'b1;
            guard = 0;
            while (exp8_q.size() > 0 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("rand_drain_left", 32'(exp8_q.size()), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("rand_sent", 32'(sent), 32'd1000);
            check("rand_ops_done", 32'(done8), 32'd1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
